// File: rtl/score_combo_if.sv
// Player-input / score-output bundle between the hit judge, the score keeper and the HUD.
interface score_combo_if;
  logic        run;
  logic        is_triggered;
  logic [1:0]  triggered_state;
  logic        note_missed;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic [3:0]  life;
  logic        game_over;
  logic        judge_valid;
  logic [1:0]  last_judge;

  modport master (
    output run, is_triggered, triggered_state, note_missed,
    input  score, combo, max_combo, life, game_over, judge_valid, last_judge
  );
  modport slave (
    input  run, is_triggered, triggered_state, note_missed,
    output score, combo, max_combo, life, game_over, judge_valid, last_judge
  );
endinterface

// File: rtl/score_combo_keeper.sv
// Rhythm-game score/combo/life keeper with an IDLE/PLAY/OVER state machine.
// Define SCORE_COMBO_BONUS_EN to double hit points once the combo reaches BONUS_TH.
module score_combo_keeper #(
  parameter int SCORE_GREAT  = 10,
  parameter int SCORE_NICE   = 5,
  parameter int SCORE_NORMAL = 2,
  parameter int LIFE_INIT    = 8,
  parameter int BONUS_TH     = 10
) (
  input  logic          system_clk,
  input  logic          rst,
  score_combo_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam logic [15:0] PTS_GREAT  = 16'(SCORE_GREAT);
  localparam logic [15:0] PTS_NICE   = 16'(SCORE_NICE);
  localparam logic [15:0] PTS_NORMAL = 16'(SCORE_NORMAL);
  localparam logic [3:0]  LIFE_MAX   = 4'(LIFE_INIT);
  localparam logic [7:0]  BONUS_THL  = 8'(BONUS_TH);
`ifdef SCORE_COMBO_BONUS_EN
  localparam logic        BONUS_EN   = 1'b1;
`else
  localparam logic        BONUS_EN   = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  combo_q, combo_d;
  logic [7:0]  max_combo_q, max_combo_d;
  logic [3:0]  life_q, life_d;
  logic        game_over_q, game_over_d;
  logic        judge_valid_q, judge_valid_d;
  logic [1:0]  last_judge_q, last_judge_d;
  logic        trig_prev_q, trig_prev_d;

  logic        hit, miss;
  logic [7:0]  combo_m;
  logic [3:0]  life_m;
  logic [15:0] pts, pts_eff;
  logic [16:0] score_sum;

  always_comb begin
    state_d       = state_q;
    score_d       = score_q;
    combo_d       = combo_q;
    max_combo_d   = max_combo_q;
    life_d        = life_q;
    last_judge_d  = last_judge_q;
    trig_prev_d   = bus.is_triggered;

    hit  = (state_q == PLAY) && bus.run && bus.is_triggered && !trig_prev_q;
    miss = (state_q == PLAY) && bus.run && bus.note_missed;

    // A coincident miss lands first; the hit then builds on the post-miss values.
    combo_m = miss ? 8'd0 : combo_q;
    life_m  = (miss && life_q != 4'd0) ? life_q - 4'd1 : life_q;

    case (bus.triggered_state)
      2'b11:   pts = PTS_GREAT;
      2'b10:   pts = PTS_NICE;
      2'b01:   pts = PTS_NORMAL;
      default: pts = 16'd0;
    endcase
    pts_eff   = (BONUS_EN && combo_m >= BONUS_THL) ? {pts[14:0], 1'b0} : pts;
    score_sum = {1'b0, score_q} + {1'b0, pts_eff};

    if (miss) begin
      combo_d      = combo_m;
      life_d       = life_m;
      last_judge_d = 2'b00;
    end
    if (hit) begin
      last_judge_d = bus.triggered_state;
      if (bus.triggered_state == 2'b00) begin
        combo_d = 8'd0;
        life_d  = (life_m != 4'd0) ? life_m - 4'd1 : life_m;
      end else begin
        combo_d = (combo_m == 8'hFF) ? combo_m : combo_m + 8'd1;
        score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        if (bus.triggered_state == 2'b11 && life_m < LIFE_MAX)
          life_d = life_m + 4'd1;
        else
          life_d = life_m;
      end
    end
    if (combo_d > max_combo_q) max_combo_d = combo_d;

    judge_valid_d = hit | miss;

    case (state_q)
      IDLE:    if (bus.run) state_d = PLAY;
      PLAY:    if (!bus.run) state_d = IDLE;
               else if (life_d == 4'd0) state_d = OVER;
      default: state_d = OVER;
    endcase
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge system_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      score_q       <= 16'd0;
      combo_q       <= 8'd0;
      max_combo_q   <= 8'd0;
      life_q        <= LIFE_MAX;
      game_over_q   <= 1'b0;
      judge_valid_q <= 1'b0;
      last_judge_q  <= 2'b01;
      trig_prev_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      combo_q       <= combo_d;
      max_combo_q   <= max_combo_d;
      life_q        <= life_d;
      game_over_q   <= game_over_d;
      judge_valid_q <= judge_valid_d;
      last_judge_q  <= last_judge_d;
      trig_prev_q   <= trig_prev_d;
    end
  end

  assign bus.score       = score_q;
  assign bus.combo       = combo_q;
  assign bus.max_combo   = max_combo_q;
  assign bus.life        = life_q;
  assign bus.game_over   = game_over_q;
  assign bus.judge_valid = judge_valid_q;
  assign bus.last_judge  = last_judge_q;

endmodule

// File: tb/tb_score_combo_keeper.sv
// Directed-vector bench for score_combo_keeper with hand-computed expectations.
module tb_score_combo_keeper;
  logic system_clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   pulses;
  int   exp_bonus;

  score_combo_if bus ();

  score_combo_keeper dut (
    .system_clk (system_clk),
    .rst        (rst),
    .bus        (bus)
  );

  always #5 system_clk = ~system_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge system_clk);
    #1;
  endtask

  task automatic hit(input logic [1:0] s);
    bus.triggered_state = s;
    bus.is_triggered    = 1'b1;
    tick();
    bus.is_triggered    = 1'b0;
    tick();
  endtask

  task automatic miss();
    bus.note_missed = 1'b1;
    tick();
    bus.note_missed = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.run = 1'b0; bus.is_triggered = 1'b0; bus.triggered_state = 2'b00; bus.note_missed = 1'b0;
    do_reset();
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_combo", 32'(bus.combo), 0);
    chk("rst_max", 32'(bus.max_combo), 0);
    chk("rst_life", 32'(bus.life), 8);
    chk("rst_over", 32'(bus.game_over), 0);
    chk("rst_jv", 32'(bus.judge_valid), 0);
    chk("rst_lj", 32'(bus.last_judge), 1);

    // GREAT, NICE, NORMAL
    bus.run = 1'b1;
    tick();
    bus.triggered_state = 2'b11; bus.is_triggered = 1'b1;
    tick();
    chk("first_jv", 32'(bus.judge_valid), 1);
    chk("first_score", 32'(bus.score), 10);
    bus.is_triggered = 1'b0;
    tick();
    chk("jv_drop", 32'(bus.judge_valid), 0);
    hit(2'b10);
    hit(2'b01);
    chk("seq_score", 32'(bus.score), 17);
    chk("seq_combo", 32'(bus.combo), 3);
    chk("seq_max", 32'(bus.max_combo), 3);
    chk("seq_life", 32'(bus.life), 8);
    chk("seq_lj", 32'(bus.last_judge), 1);

    // Held level counts once
    pulses = 0;
    bus.triggered_state = 2'b11; bus.is_triggered = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += int'(bus.judge_valid);
    end
    bus.is_triggered = 1'b0;
    tick();
    pulses += int'(bus.judge_valid);
    chk("hold_pulses", 32'(pulses), 1);
    chk("hold_score", 32'(bus.score), 27);
    chk("hold_combo", 32'(bus.combo), 4);

    // Miss + NICE in the same cycle
    bus.note_missed = 1'b1; bus.is_triggered = 1'b1; bus.triggered_state = 2'b10;
    tick();
    chk("mn_combo", 32'(bus.combo), 1);
    chk("mn_max", 32'(bus.max_combo), 4);
    chk("mn_life", 32'(bus.life), 7);
    chk("mn_score", 32'(bus.score), 32);
    chk("mn_lj", 32'(bus.last_judge), 2);
    chk("mn_jv", 32'(bus.judge_valid), 1);
    bus.note_missed = 1'b0; bus.is_triggered = 1'b0;
    tick();
    chk("mn_jv_drop", 32'(bus.judge_valid), 0);
    chk("mn_lj_hold", 32'(bus.last_judge), 2);

    // BAD hit, then a plain miss
    hit(2'b00);
    chk("bad_combo", 32'(bus.combo), 0);
    chk("bad_life", 32'(bus.life), 6);
    chk("bad_score", 32'(bus.score), 32);
    chk("bad_lj", 32'(bus.last_judge), 0);
    miss();
    chk("miss_life", 32'(bus.life), 5);

    // Pause: events ignored, held level does not re-trigger on resume
    bus.run = 1'b0;
    tick();
    bus.is_triggered = 1'b1; bus.triggered_state = 2'b11;
    tick();
    chk("pause_jv", 32'(bus.judge_valid), 0);
    bus.note_missed = 1'b1;
    tick();
    bus.note_missed = 1'b0;
    chk("pause_life", 32'(bus.life), 5);
    bus.run = 1'b1;
    tick();
    tick();
    chk("resume_jv", 32'(bus.judge_valid), 0);
    chk("resume_score", 32'(bus.score), 32);
    bus.is_triggered = 1'b0;
    tick();

    // GREAT + miss: net life unchanged
    bus.note_missed = 1'b1; bus.is_triggered = 1'b1; bus.triggered_state = 2'b11;
    tick();
    chk("gm_life", 32'(bus.life), 5);
    chk("gm_combo", 32'(bus.combo), 1);
    chk("gm_score", 32'(bus.score), 42);
    bus.note_missed = 1'b0; bus.is_triggered = 1'b0;
    tick();

    // BAD + miss: life -2
    bus.note_missed = 1'b1; bus.is_triggered = 1'b1; bus.triggered_state = 2'b00;
    tick();
    chk("bm_life", 32'(bus.life), 3);
    chk("bm_combo", 32'(bus.combo), 0);
    bus.note_missed = 1'b0;

    // Reset wins over a coincident hit mid-PLAY
    bus.is_triggered = 1'b0;
    tick();
    bus.is_triggered = 1'b1; bus.triggered_state = 2'b11; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstp_score", 32'(bus.score), 0);
    chk("rstp_jv", 32'(bus.judge_valid), 0);
    chk("rstp_life", 32'(bus.life), 8);
    chk("rstp_max", 32'(bus.max_combo), 0);
    tick();
    tick();
    chk("rstp_held_score", 32'(bus.score), 0);
    bus.is_triggered = 1'b0;
    tick();

    // Eight misses -> OVER
    for (int i = 0; i < 7; i++) miss();
    chk("m7_life", 32'(bus.life), 1);
    chk("m7_over", 32'(bus.game_over), 0);
    miss();
    chk("m8_life", 32'(bus.life), 0);
    chk("m8_over", 32'(bus.game_over), 1);
    bus.triggered_state = 2'b11; bus.is_triggered = 1'b1;
    tick();
    chk("over_jv", 32'(bus.judge_valid), 0);
    bus.is_triggered = 1'b0;
    tick();
    hit(2'b10);
    chk("over_score", 32'(bus.score), 0);
    chk("over_combo", 32'(bus.combo), 0);
    bus.run = 1'b0;
    tick();
    chk("over_persist", 32'(bus.game_over), 1);
    do_reset();
    chk("over_rst", 32'(bus.game_over), 0);
    chk("over_rst_life", 32'(bus.life), 8);

    // 11 GREATs: bonus only on the 11th (pre-hit combo 10)
    bus.run = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) hit(2'b11);
`ifdef SCORE_COMBO_BONUS_EN
    exp_bonus = 120;
`else
    exp_bonus = 110;
`endif
    chk("bonus_score", 32'(bus.score), 32'(exp_bonus));
    chk("bonus_combo", 32'(bus.combo), 11);

    // Saturation of score and combo
    do_reset();
    tick();
    for (int i = 0; i < 6554; i++) hit(2'b11);
    chk("sat_score", 32'(bus.score), 32'hFFFF);
    chk("sat_combo", 32'(bus.combo), 255);
    chk("sat_max", 32'(bus.max_combo), 255);
    chk("sat_life", 32'(bus.life), 8);
    hit(2'b10);
    chk("sat_hold", 32'(bus.score), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
